code_decode_disp: RTL and testbench
===================================

# code_decode_disp

Registered receiver for the 8-to-3 priority encoder's output code: takes an encoder result {valid, index[2:0]} from the board, synchronizes and debounces it, and decodes it back into a one-hot LED pattern and a 7-segment digit. It also counts accepted code changes and shows the count as a hex digit. It sits on the nvboard between the encoder outputs (or raw switches) and the LED/segment pins.

## Interface
- STABLE_CYCLES, default 4: cycles a synchronized code must hold unchanged before it is accepted; legal range 1..255.
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- code_valid  input  1  encoder "any input active" flag; asynchronous to clk.
- code  input  3  encoder index 0..7; ignored when code_valid=0.
- onehot  output  8  decoded LEDs: bit[code] set when accepted valid, else 0.
- none  output  1  1 when the accepted code is invalid.
- seg0  output  8  active-low segments {a,b,c,d,e,f,g,dp} (bit7=a) showing accepted index 0..7; blank (8'hFF) when invalid.
- seg1  output  8  active-low segments showing change count 0..F in hex.

## Operation
- Synchronizer: 2-flop chain on the 4-bit word {code_valid, code}; the result is s2.
- Normalization: when s2.valid=0, the code field is treated as 000. Compared words are therefore {0,000} or {1,idx}.
- Filter: holds a candidate register cand and a counter cnt of width $clog2(STABLE_CYCLES+1).
  - If s2 != cand: cand<=s2, cnt<=0.
  - Else if cnt < STABLE_CYCLES-1: cnt<=cnt+1.
  - Else (cnt == STABLE_CYCLES-1, saturated): if cand != acc, commit. cnt holds.
- Commit (one cycle):
  - acc<=cand.
  - onehot, none, seg0 are reloaded from cand.
  - chg_cnt<=chg_cnt+1, 4-bit, wraps F->0; seg1 is reloaded from the new count.
- No commit when cand == acc. Re-presenting the same code after a glitch does not bump the counter.
- Glitch rule: any s2 pulse shorter than STABLE_CYCLES cycles never reaches acc.
- Digit patterns before inversion: 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=F6, A=EE, b=3E, C=9C, d=7A, E=9E, F=8E. Outputs carry the bitwise complement.
- Reset values (async, while rst_n=0):
  - sync flops, cand, acc = {0,000}; cnt=0; chg_cnt=0.
  - onehot=8'h00, none=1, seg0=8'hFF, seg1=~FC=8'h03.
- Reset mid-filter: all progress is discarded. After release, the pending input restarts the full latency.

## Timing
- Latency: input applied and held before edge 1; s2 valid after edge 2; cand loaded at edge 3; outputs update at edge STABLE_CYCLES+3. With the default, that is edge 7.
- All outputs are registered and glitch-free. They change only on a commit edge or on reset.
- Input changing at the commit edge: the commit still uses the old cand. The new value reloads cand on a later edge and restarts cnt.
- Back-to-back distinct stable codes: each produces exactly one commit and one count increment.

## Structure
- Package decode_pkg holds:
  - SEG_BLANK (8'hFF).
  - the 16-entry active-high digit constant array.
  - the {valid, idx} struct typedef.
  - STABLE_CYCLES range check as a localparam assertion.
- Sub-module seg7_hex: 4-bit value in, active-low 8-bit pattern out, purely combinational. Instantiated twice:
  - seg0 path, with input {1'b0, idx} and blank forced when invalid.
  - seg1 path, fed by chg_cnt.
- Top holds the synchronizer, filter, commit registers and counter, within 120-250 lines.

## Test plan
- Reset: assert rst_n=0 mid-run -> immediately onehot=00, none=1, seg0=FF, seg1=03; after release with code_valid=0 held, no change for 20 cycles.
- Accept: valid=1, code=5 held -> at edge 7, onehot=20, none=0, seg0=49 (~B6), seg1=9F (~60); no change before edge 7.
- Glitch: from accepted 5, pulse code=2 for 3 cycles then back to 5 -> outputs and seg1 unchanged throughout.
- Invalid: drop code_valid with code=3 -> after 7 cycles onehot=00, none=1, seg0=FF, count +1.
- Wrap: 16 alternating stable codes 0/7 -> seg1 steps through 1..F then 0 (03); onehot alternates 01/80.
- STABLE_CYCLES=1 build: code 4 -> outputs at edge 4, onehot=10, seg0=99.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types and constants for the encoder-code receiver: the {valid, idx}
// word, 7-segment digit table and the filter-length legality check.
package decode_pkg;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } code_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-high {a,b,c,d,e,f,g,dp} patterns, element 0 is digit 0.
  localparam logic [0:15][7:0] SEG_DIGITS = {
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };

  localparam int STABLE_MIN = 1;
  localparam int STABLE_MAX = 255;

  function automatic bit stable_cycles_ok(input int n);
    return (n >= STABLE_MIN) && (n <= STABLE_MAX);
  endfunction

endpackage

// File: rtl/seg7_hex.sv
// Combinational hex-to-7-segment decoder with active-low outputs and a blank
// override.
module seg7_hex
  import decode_pkg::*;
(
  input  logic [3:0] value,
  input  logic       blank,
  output logic [7:0] seg
);

  assign seg = blank ? SEG_BLANK : ~SEG_DIGITS[value];

endmodule

// File: rtl/code_decode_disp.sv
// Synchronizes and debounces an encoder {valid, idx} result, decodes the
// accepted code to LEDs and a digit, and shows a hex count of accepted changes.
module code_decode_disp
  import decode_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       code_valid,
  input  logic [2:0] code,
  output logic [7:0] onehot,
  output logic       none,
  output logic [7:0] seg0,
  output logic [7:0] seg1
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam bit STABLE_OK = stable_cycles_ok(STABLE_CYCLES);

  generate
    if (!STABLE_OK) begin : g_bad_stable_cycles
      $error("code_decode_disp: STABLE_CYCLES must be within 1..255");
    end
  endgenerate

  code_t          s1_reg, s2_reg;
  code_t          s2_norm;
  code_t          cand_reg, acc_reg;
  logic [CW-1:0]  cnt_reg;
  logic [3:0]     chg_cnt_reg;
  logic [3:0]     chg_cnt_next;
  logic           commit;

  logic [7:0]     onehot_reg, onehot_next;
  logic           none_reg;
  logic [7:0]     seg0_reg, seg0_next;
  logic [7:0]     seg1_reg, seg1_next;

  // The index is meaningless without valid, so fold it to zero before filtering.
  assign s2_norm.valid = s2_reg.valid;
  assign s2_norm.idx   = s2_reg.valid ? s2_reg.idx : 3'd0;

  assign commit       = (s2_norm == cand_reg) && (cnt_reg == CNT_LAST) && (cand_reg != acc_reg);
  assign chg_cnt_next = chg_cnt_reg + 4'd1;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_onehot
      assign onehot_next[gi] = cand_reg.valid && (cand_reg.idx == 3'(gi));
    end
  endgenerate

  seg7_hex u_seg_idx (
    .value ({1'b0, cand_reg.idx}),
    .blank (~cand_reg.valid),
    .seg   (seg0_next)
  );

  seg7_hex u_seg_cnt (
    .value (chg_cnt_next),
    .blank (1'b0),
    .seg   (seg1_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg <= '0;
      s2_reg <= '0;
    end else begin
      s1_reg <= {code_valid, code};
      s2_reg <= s1_reg;
    end
  end

  // Candidate filter: a new word restarts the count, a held word saturates it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_reg <= '0;
      cnt_reg  <= '0;
    end else if (s2_norm != cand_reg) begin
      cand_reg <= s2_norm;
      cnt_reg  <= '0;
    end else if (cnt_reg < CNT_LAST) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg     <= '0;
      chg_cnt_reg <= '0;
      onehot_reg  <= 8'h00;
      none_reg    <= 1'b1;
      seg0_reg    <= SEG_BLANK;
      seg1_reg    <= ~SEG_DIGITS[0];
    end else if (commit) begin
      acc_reg     <= cand_reg;
      chg_cnt_reg <= chg_cnt_next;
      onehot_reg  <= onehot_next;
      none_reg    <= ~cand_reg.valid;
      seg0_reg    <= seg0_next;
      seg1_reg    <= seg1_next;
    end
  end

  assign onehot = onehot_reg;
  assign none   = none_reg;
  assign seg0   = seg0_reg;
  assign seg1   = seg1_reg;

endmodule

// File: tb/tb_code_decode_disp.sv
// Directed bench for code_decode_disp: default filter length plus a
// STABLE_CYCLES=1 instance.
module tb_code_decode_disp;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       code_valid, code_valid1;
  logic [2:0] code, code1;
  logic [7:0] onehot, seg0, seg1;
  logic       none;
  logic [7:0] onehot1, seg0_1, seg1_1;
  logic       none1;

  int checks = 0;
  int errors = 0;

  // Active-low patterns for 0..F, written out by hand.
  logic [7:0] seg_exp [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  always #5 clk = ~clk;

  code_decode_disp #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .code_valid(code_valid), .code(code),
    .onehot(onehot), .none(none), .seg0(seg0), .seg1(seg1)
  );

  code_decode_disp #(.STABLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .code_valid(code_valid1), .code(code1),
    .onehot(onehot1), .none(none1), .seg0(seg0_1), .seg1(seg1_1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_oh, input logic e_none,
                         input logic [7:0] e_s0, input logic [7:0] e_s1);
    chk({tag, ".onehot"}, onehot, e_oh);
    chk({tag, ".none"}, {7'd0, none}, {7'd0, e_none});
    chk({tag, ".seg0"}, seg0, e_s0);
    chk({tag, ".seg1"}, seg1, e_s1);
  endtask

  initial begin
    rst_n = 1'b0;
    code_valid = 1'b0; code = 3'd0;
    code_valid1 = 1'b0; code1 = 3'd0;
    tick(); tick();
    chk_all("reset", 8'h00, 1'b1, 8'hFF, 8'h03);
    $display("reset: onehot=%h none=%b seg0=%h seg1=%h", onehot, none, seg0, seg1);
    #4 rst_n = 1'b1;
    tick();

    // Accept code 5: outputs move exactly at edge 7.
    code_valid = 1'b1; code = 3'd5;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k < 7) chk_all($sformatf("accept_e%0d", k), 8'h00, 1'b1, 8'hFF, 8'h03);
    end
    chk_all("accept", 8'h20, 1'b0, 8'h49, 8'h9F);
    $display("accept code=5: onehot=%h none=%b seg0=%h seg1=%h", onehot, none, seg0, seg1);

    // Three-cycle glitch to 2 must be absorbed.
    code = 3'd2;
    tick(); tick(); tick();
    code = 3'd5;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk($sformatf("glitch_oh%0d", k), onehot, 8'h20);
      chk($sformatf("glitch_s1_%0d", k), seg1, 8'h9F);
    end
    $display("glitch code=2x3: onehot=%h seg1=%h", onehot, seg1);

    // Drop valid with a nonzero code: accepted as invalid, count 2.
    code_valid = 1'b0; code = 3'd3;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 6) chk_all("invalid_e6", 8'h20, 1'b0, 8'h49, 8'h9F);
    end
    chk_all("invalid", 8'h00, 1'b1, 8'hFF, 8'h25);
    $display("invalid: onehot=%h none=%b seg0=%h seg1=%h", onehot, none, seg0, seg1);

    // Reset in the middle of a pending code 6.
    code_valid = 1'b1; code = 3'd6;
    tick(); tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk_all("midreset", 8'h00, 1'b1, 8'hFF, 8'h03);
    code_valid = 1'b0; code = 3'd0;
    tick();
    #3 rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("idle_oh%0d", k), onehot, 8'h00);
      chk($sformatf("idle_s1_%0d", k), seg1, 8'h03);
    end
    $display("midreset: onehot=%h none=%b seg0=%h seg1=%h", onehot, none, seg0, seg1);

    // Sixteen alternating codes 0/7: counter walks 1..F then wraps to 0.
    code_valid = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      code = (i % 2 == 1) ? 3'd0 : 3'd7;
      for (int k = 0; k < 8; k++) tick();
      chk($sformatf("wrap%0d.onehot", i), onehot, (i % 2 == 1) ? 8'h01 : 8'h80);
      chk($sformatf("wrap%0d.seg1", i), seg1, seg_exp[i % 16]);
      $display("wrap %0d code=%0d: onehot=%h seg1=%h", i, code, onehot, seg1);
    end
    chk("wrap.seg0", seg0, 8'h1F);

    // STABLE_CYCLES=1 instance: code 4 appears at edge 4.
    code_valid1 = 1'b1; code1 = 3'd4;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k < 4) chk($sformatf("fast_e%0d", k), onehot1, 8'h00);
    end
    chk("fast.onehot", onehot1, 8'h10);
    chk("fast.seg0", seg0_1, 8'h99);
    chk("fast.seg1", seg1_1, 8'h9F);
    chk("fast.none", {7'd0, none1}, 8'h00);
    $display("fast code=4: onehot=%h seg0=%h seg1=%h", onehot1, seg0_1, seg1_1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
